// File: rtl/julia_dispatch_pkg.sv
// rtl/julia_dispatch_pkg.sv - shared state encoding and default widths for the Julia pixel dispatcher
package julia_dispatch_pkg;

    localparam int DEF_NUM_WORKERS = 16;
    localparam int DEF_X_BITS      = 10;
    localparam int DEF_Y_BITS      = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } disp_state_e;

    // Index width that stays legal for a single-worker build.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/julia_dispatch_rr_arbiter.sv
// rtl/julia_dispatch_rr_arbiter.sv - combinational round-robin pick, search starts at ptr_i
module julia_dispatch_rr_arbiter #(
    parameter int N  = 16,
    parameter int PW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/julia_dispatch_rr.sv
// rtl/julia_dispatch_rr.sv - raster-order pixel dispatcher feeding Julia workers by round-robin
module julia_dispatch_rr
    import julia_dispatch_pkg::*;
#(
    parameter int NUM_WORKERS = DEF_NUM_WORKERS,
    parameter int X_BITS      = DEF_X_BITS,
    parameter int Y_BITS      = DEF_Y_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [X_BITS-1:0]             frame_w,
    input  logic [Y_BITS-1:0]             frame_h,
    input  logic [NUM_WORKERS-1:0]        jw_dp_ready,
    output logic [NUM_WORKERS-1:0]        dp_jw_start,
    output logic [NUM_WORKERS*X_BITS-1:0] x_reg,
    output logic [NUM_WORKERS*Y_BITS-1:0] y_reg,
    output logic                          busy,
    output logic                          done,
    output logic [X_BITS+Y_BITS-1:0]      pix_count
);

    localparam int PW = idx_bits(NUM_WORKERS);
    localparam int CW = X_BITS + Y_BITS;

    disp_state_e                   state_q, state_d;
    logic [X_BITS-1:0]             cur_x_q, cur_x_d, fw_q;
    logic [Y_BITS-1:0]             cur_y_q, cur_y_d, fh_q;
    logic [NUM_WORKERS-1:0]        pend_q, pend_d, start_q;
    logic [PW-1:0]                 ptr_q, ptr_d;
    logic [NUM_WORKERS*X_BITS-1:0] x_q;
    logic [NUM_WORKERS*Y_BITS-1:0] y_q;
    logic [CW-1:0]                 pix_q;
    logic                          done_q;
    logic [NUM_WORKERS-1:0]        grant_oh;
    logic [PW-1:0]                 grant_idx;
    logic                          grant_vld;
    logic                          start_ok, size_zero, row_end, last_pix, dispatch;

    assign start_ok  = start && !abort && (state_q == IDLE || state_q == DONE);
    assign size_zero = (frame_w == '0) || (frame_h == '0);
    assign row_end   = (cur_x_q == fw_q - X_BITS'(1));
    assign last_pix  = row_end && (cur_y_q == fh_q - Y_BITS'(1));

    // A worker whose ready has not yet fallen after a dispatch is held off by pend_q.
    julia_dispatch_rr_arbiter #(.N(NUM_WORKERS), .PW(PW)) u_arb (
        .req_i   (jw_dp_ready & ~pend_q),
        .ptr_i   (ptr_q),
        .grant_o (grant_oh),
        .idx_o   (grant_idx),
        .valid_o (grant_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_ok) state_d = size_zero ? DONE : DISPATCH;
            DISPATCH: if (grant_vld && last_pix) state_d = DRAIN;
            DRAIN:    if (pend_q == '0 && (&jw_dp_ready)) state_d = DONE;
            DONE:     state_d = start_ok ? (size_zero ? DONE : DISPATCH) : IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy     = (state_q == DISPATCH) || (state_q == DRAIN);
        dispatch = (state_q == DISPATCH) && grant_vld && !abort;
    end

    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        pend_d  = pend_q & jw_dp_ready;
        ptr_d   = ptr_q;
        if (dispatch) begin
            pend_d = pend_d | grant_oh;
            ptr_d  = (grant_idx == PW'(NUM_WORKERS - 1)) ? '0 : grant_idx + PW'(1);
            if (row_end) begin
                cur_x_d = '0;
                cur_y_d = cur_y_q + Y_BITS'(1);
            end else begin
                cur_x_d = cur_x_q + X_BITS'(1);
            end
        end
        if (start_ok) begin
            cur_x_d = '0;
            cur_y_d = '0;
        end
        if (abort) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
            fw_q    <= '0;
            fh_q    <= '0;
            pend_q  <= '0;
            ptr_q   <= '0;
            start_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            start_q <= dispatch ? grant_oh : '0;
            done_q  <= (state_q == DONE) && !abort;
            if (start_ok) begin
                fw_q  <= frame_w;
                fh_q  <= frame_h;
                pix_q <= '0;
            end else if (dispatch) begin
                pix_q <= pix_q + CW'(1);
            end
            if (dispatch) begin
                x_q[int'(grant_idx)*X_BITS +: X_BITS] <= cur_x_q;
                y_q[int'(grant_idx)*Y_BITS +: Y_BITS] <= cur_y_q;
            end
        end
    end

    assign dp_jw_start = start_q;
    assign x_reg       = x_q;
    assign y_reg       = y_q;
    assign done        = done_q;
    assign pix_count   = pix_q;

endmodule

// File: tb/tb_julia_dispatch_rr.sv
// tb/tb_julia_dispatch_rr.sv - scoreboard bench for julia_dispatch_rr (16-worker and 1-worker builds)
module tb_julia_dispatch_rr;

    localparam int N  = 16;
    localparam int XB = 10;
    localparam int YB = 10;

    typedef struct {
        int w;
        int x;
        int y;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, abort;
    logic [XB-1:0]  fw;
    logic [YB-1:0]  fh;
    logic [N-1:0]   ready, rdy_auto, auto_mask, man_rdy;
    logic [N-1:0]   dp;
    logic [N*XB-1:0] xr;
    logic [N*YB-1:0] yr;
    logic           busy, done;
    logic [XB+YB-1:0] pix;

    logic       start_b, abort_b, rdy_b, dp_b, busy_b, done_b;
    logic [3:0] fw_b, fh_b, x_b, y_b;
    logic [7:0] pix_b;

    int total = 0;
    int bad   = 0;
    int pulses = 0, done_cnt = 0, pulses_b = 0, done_b_cnt = 0;
    int hold [N];
    exp_t sb_q [$];
    int   xb_q [$];

    assign ready = (auto_mask & rdy_auto) | (~auto_mask & man_rdy);

    julia_dispatch_rr #(.NUM_WORKERS(N), .X_BITS(XB), .Y_BITS(YB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .frame_w(fw), .frame_h(fh), .jw_dp_ready(ready),
        .dp_jw_start(dp), .x_reg(xr), .y_reg(yr),
        .busy(busy), .done(done), .pix_count(pix)
    );

    julia_dispatch_rr #(.NUM_WORKERS(1), .X_BITS(4), .Y_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .frame_w(fw_b), .frame_h(fh_b), .jw_dp_ready(rdy_b),
        .dp_jw_start(dp_b), .x_reg(x_b), .y_reg(y_b),
        .busy(busy_b), .done(done_b), .pix_count(pix_b)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Worker array model and scoreboard consumer; auto workers drop ready for two cycles per pixel.
    always @(negedge clk) begin
        if (rst) begin
            rdy_auto = '1;
            rdy_b    = 1'b1;
            for (int i = 0; i < N; i++) hold[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) rdy_auto[i] = 1'b1;
                end
            end
            if (dp != '0) begin
                pulses++;
                chk("onehot", $countones(dp), 1);
                for (int i = 0; i < N; i++) begin
                    if (dp[i]) begin
                        if (sb_q.size() == 0) begin
                            chk("unexpected_pulse", i, -1);
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            chk("worker", i, e.w);
                            chk("x", xr[i*XB +: XB], e.x);
                            chk("y", yr[i*YB +: YB], e.y);
                        end
                        rdy_auto[i] = 1'b0;
                        hold[i]     = 2;
                    end
                end
            end
            if (done) done_cnt++;
            if (dp_b) begin
                pulses_b++;
                if (xb_q.size() == 0) chk("b_unexpected_pulse", x_b, -1);
                else chk("b_x", x_b, xb_q.pop_front());
                chk("b_y", y_b, 0);
                rdy_b = 1'b0;
            end else begin
                rdy_b = 1'b1;
            end
            if (done_b) done_b_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_b = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic go(input int w, input int h);
        fw = XB'(w);
        fh = YB'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input int w, input int x, input int y);
        exp_t e;
        e.w = w; e.x = x; e.y = y;
        sb_q.push_back(e);
    endtask

    task automatic wait_pulses(input string tag, input int target);
        for (int k = 0; k < 200 && pulses < target; k++) tick();
        chk(tag, pulses, target);
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int k = 0; k < 200 && done_cnt == base; k++) tick();
        chk(tag, done_cnt, base + 1);
    endtask

    initial begin
        int base, dbase;
        int order [20];
        abort_b = 1'b0;
        fw_b = '0;
        fh_b = '0;
        fw = '0;
        fh = '0;
        auto_mask = '1;
        man_rdy = '0;
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_start", dp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix", pix, 0);
        chk("rst_xreg", xr == '0, 1);
        chk("rst_yreg", yr == '0, 1);
        rst = 1'b0;

        // 4x2 frame, everyone free: workers 0..7 in raster order, first pulse two cycles after start
        do_reset();
        for (int i = 0; i < 8; i++) push(i, i % 4, i / 4);
        base = pulses; dbase = done_cnt;
        go(4, 2);
        chk("t1_lat1_start", dp, 0);
        chk("t1_lat1_busy", busy, 1);
        tick();
        chk("t1_lat2_start", dp, 1);
        wait_done("t1_done", dbase);
        chk("t1_pulses", pulses - base, 8);
        chk("t1_pix", pix, 8);
        chk("t1_busy_after", busy, 0);
        chk("t1_sb_empty", sb_q.size(), 0);

        // ready stuck high on workers 0 and 2: one pixel each, then stall until ready toggles
        do_reset();
        auto_mask = '0;
        man_rdy = 16'h0005;
        push(0, 0, 0);
        push(2, 1, 0);
        base = pulses;
        go(4, 1);
        repeat (12) tick();
        chk("t2_stall_pulses", pulses - base, 2);
        chk("t2_stall_pix", pix, 2);
        chk("t2_stall_busy", busy, 1);
        push(0, 2, 0);
        man_rdy[0] = 1'b0;
        tick();
        man_rdy[0] = 1'b1;
        repeat (4) tick();
        chk("t2_w0_again", pulses - base, 3);
        push(2, 3, 0);
        man_rdy[2] = 1'b0;
        tick();
        man_rdy[2] = 1'b1;
        repeat (4) tick();
        chk("t2_w2_again", pulses - base, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t2_abort_busy", busy, 0);
        chk("t2_pix", pix, 4);

        // worker 3 permanently busy on a 20x1 frame: it is skipped on both laps
        do_reset();
        auto_mask = '1;
        auto_mask[3] = 1'b0;
        man_rdy = '0;
        for (int i = 0; i < 15; i++) order[i] = (i < 3) ? i : i + 1;
        order[15] = 0; order[16] = 1; order[17] = 2; order[18] = 4; order[19] = 5;
        for (int i = 0; i < 20; i++) push(order[i], i, 0);
        base = pulses; dbase = done_cnt;
        go(20, 1);
        wait_pulses("t3_pulses", base + 20);
        man_rdy[3] = 1'b1;
        wait_done("t3_done", dbase);
        chk("t3_pix", pix, 20);
        chk("t3_sb_empty", sb_q.size(), 0);

        // abort after five pixels, then a fresh frame resumes rr at worker 5 from (0,0)
        do_reset();
        auto_mask = '1;
        for (int i = 0; i < 5; i++) push(i, i, 0);
        base = pulses; dbase = done_cnt;
        go(8, 4);
        wait_pulses("t4_five", base + 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_start", dp, 0);
        chk("t4_abort_pix", pix, 5);
        repeat (6) tick();
        chk("t4_no_done", done_cnt, dbase);
        chk("t4_no_more", pulses - base, 5);
        chk("t4_pix_hold", pix, 5);
        push(5, 0, 0);
        push(6, 1, 0);
        go(2, 1);
        wait_done("t4_restart_done", dbase);
        chk("t4_restart_pix", pix, 2);

        // zero-width frame: done two cycles after start, nothing dispatched
        base = pulses;
        go(0, 3);
        chk("t5_done_early", done, 0);
        tick();
        chk("t5_done", done, 1);
        tick();
        chk("t5_done_once", done, 0);
        chk("t5_no_pulse", pulses, base);
        chk("t5_pix", pix, 0);

        // single-worker build, 15x1 frame; a second start while busy must be ignored
        for (int i = 0; i < 15; i++) xb_q.push_back(i);
        fw_b = 4'd15;
        fh_b = 4'd1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 50 && pulses_b < 1; k++) tick();
        chk("t6_first", pulses_b, 1);
        chk("t6_busy", busy_b, 1);
        fw_b = 4'd3;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 200 && done_b_cnt == 0; k++) tick();
        chk("t6_done", done_b_cnt, 1);
        chk("t6_pulses", pulses_b, 15);
        chk("t6_last_x", x_b, 14);
        chk("t6_pix", pix_b, 15);
        chk("t6_sb_empty", xb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
